m_ext_sequencer: RTL and testbench
==================================

Name: m_ext_sequencer

Overview:
- Multi-cycle controller and iterative datapath for RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) in the EX stage.
- Accepts an op when the decoded control word has m_extension_act set, stalls the pipeline while iterating, then holds the result until EX advances.
- Shares one 64-bit shift register between shift-add multiply and restoring divide.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start_i  input  1  EX holds a valid instruction with m_extension_act=1
- funct3_i  input  3  M op: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- rs1_i  input  XLEN  forwarded rs1 operand
- rs2_i  input  XLEN  forwarded rs2 operand
- flush_i  input  1  branch/jump flush of EX; aborts the op
- ack_i  input  1  EX/MEM pipeline register loads this cycle
- stall_o  output  1  freeze IF/ID/EX
- done_o  output  1  result_o valid
- result_o  output  XLEN  final result

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). On reset: state=IDLE, counter=0, internal registers=0. stall_o=0, done_o=0, result_o=0.
- States:
  - IDLE: waiting for an op.
  - BUSY: iterating.
  - DONE: result held.
- IDLE:
  - stall_o = start_i & ~flush_i (combinational, same cycle).
  - On start_i & ~flush_i, latch funct3, operand magnitudes and sign-fix flags.
  - Special case (div/divu/rem/remu with rs2=0, or signed div/rem with rs1=0x80000000 and rs2=0xFFFFFFFF): go directly to DONE with the special result.
  - Otherwise go to BUSY with count=0.
- BUSY:
  - stall_o=1. One multiply or divide step per cycle; count increments.
  - When count==XLEN-1, go to DONE.
  - Total stall for a normal op: XLEN+1 cycles. Start sampled in cycle N; done_o=1 in cycle N+XLEN+1.
- DONE:
  - stall_o=0, done_o=1, result_o stable.
  - On ack_i, go to IDLE. start_i is ignored in DONE, including when start_i and ack_i are high in the same cycle; the next op is sampled in IDLE the following cycle.
- flush_i: in any state, next state is IDLE and done_o deasserts next cycle. flush_i has priority over start_i and ack_i. While in IDLE, flush_i suppresses stall_o in the same cycle.
- Multiply arithmetic:
  - Operate on unsigned magnitudes.
  - Signed operands: mulh treats both as signed; mulhsu treats rs1 as signed, rs2 as unsigned.
  - 64-bit product is negated if the effective signs differ.
  - mul returns product[31:0]; mulh/mulhsu/mulhu return product[63:32].
- Divide arithmetic:
  - Restoring divide on magnitudes (signed for div/rem).
  - Quotient is negated if the signs of rs1 and rs2 differ.
  - Remainder takes the sign of rs1.
- Special results:
  - Divide by zero: quotient=0xFFFFFFFF, remainder=rs1.
  - Signed overflow: quotient=0x80000000, remainder=0.
- result_o is only meaningful when done_o=1; it holds its last value otherwise.
- Operand changes on rs1_i/rs2_i after acceptance are ignored (values are latched in IDLE).
- Reset mid-operation: immediate return to reset state; no partial result is exposed.

Test Plan:
- mul, rs1=7, rs2=0xFFFFFFFD -> stall_o high 33 cycles, done_o with result_o=0xFFFFFFEB; ack_i -> IDLE, stall_o=0.
- mulh, rs1=rs2=0x80000000 -> result_o=0x40000000. mulhu, rs1=rs2=0xFFFFFFFF -> result_o=0xFFFFFFFE. mulhsu, rs1=0xFFFFFFFF, rs2=2 -> result_o=0xFFFFFFFF.
- div, rs1=0xFFFFFFF9 (-7), rs2=2 -> result_o=0xFFFFFFFD. rem with same operands -> result_o=0xFFFFFFFF. divu, rs1=100, rs2=7 -> result_o=14. remu with same operands -> result_o=2.
- div, rs2=0 -> 1 stall cycle, result_o=0xFFFFFFFF. remu, rs1=0x1234, rs2=0 -> result_o=0x1234. div, rs1=0x80000000, rs2=0xFFFFFFFF -> result_o=0x80000000, 1 stall cycle. rem with same operands -> result_o=0.
- Flush in BUSY at count 10 -> IDLE next cycle, done_o never asserts. A new start 2 cycles later produces the correct fresh result.
- Back-to-back ops:
  - Hold start_i high with ack_i=0 in DONE for 3 cycles -> result_o stable, no restart.
  - ack_i with start_i high -> IDLE; a second op (divu 9/3) is accepted the next cycle -> result_o=3.
- Reset asserted mid-BUSY -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/m_ext_sequencer_if.sv
// rtl/m_ext_sequencer_if.sv - EX-stage handshake bundle for the RV32M sequencer
//
// Purpose: groups the EX-stage request, pipeline control and result signals
// of the M-extension sequencer.
// Ports (signals):
//   start_i  - EX holds a valid M-extension instruction
//   funct3_i - M op select
//   rs1_i    - forwarded rs1 operand
//   rs2_i    - forwarded rs2 operand
//   flush_i  - branch/jump flush of EX, aborts the op
//   ack_i    - EX/MEM pipeline register loads this cycle
//   stall_o  - freeze IF/ID/EX
//   done_o   - result_o valid
//   result_o - final result
// Modports: master = EX stage side, slave = sequencer side.
interface m_ext_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            ack_i;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, funct3_i, rs1_i, rs2_i, flush_i, ack_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, rs1_i, rs2_i, flush_i, ack_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/m_ext_sequencer.sv
// rtl/m_ext_sequencer.sv - multi-cycle RV32M multiply/divide sequencer for EX
//
// Purpose: accepts an M-extension op from EX, stalls the pipeline for XLEN
// iterations of shift-add multiply or restoring divide on operand
// magnitudes, then holds the signed-corrected result until EX advances.
// Divide-by-zero and signed overflow finish in a single stall cycle.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   bus - m_ext_sequencer_if.slave (start/funct3/rs1/rs2/flush/ack in,
//         stall/done/result out)
module m_ext_sequencer #(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              rst,
  m_ext_sequencer_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic              neg_q;      // negate product / quotient
  logic              neg_r;      // negate remainder (sign of rs1)
  logic [XLEN-1:0]   operand_b;  // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc;        // shared shift register
  logic [XLEN-1:0]   result_q;

  logic accept;
  assign accept = (state == S_IDLE) & bus.start_i & ~bus.flush_i;

  // Operand signedness: mulh/mulhsu/div/rem treat rs1 as signed,
  // mulh/div/rem treat rs2 as signed.
  logic sgn1, sgn2, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  assign sgn1  = (bus.funct3_i == 3'b001) | (bus.funct3_i == 3'b010) |
                 (bus.funct3_i == 3'b100) | (bus.funct3_i == 3'b110);
  assign sgn2  = (bus.funct3_i == 3'b001) | (bus.funct3_i == 3'b100) |
                 (bus.funct3_i == 3'b110);
  assign a_neg = sgn1 & bus.rs1_i[XLEN-1];
  assign b_neg = sgn2 & bus.rs2_i[XLEN-1];
  assign mag_a = a_neg ? -bus.rs1_i : bus.rs1_i;
  assign mag_b = b_neg ? -bus.rs2_i : bus.rs2_i;

  // Cases that bypass iteration entirely.
  logic            is_div0, is_ovf;
  logic [XLEN-1:0] special_res;
  assign is_div0 = bus.funct3_i[2] & (bus.rs2_i == '0);
  assign is_ovf  = bus.funct3_i[2] & ~bus.funct3_i[0] &
                   (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (bus.rs2_i == '1);

  always_comb begin
    special_res = '0;
    if (is_div0) begin
      special_res = bus.funct3_i[1] ? bus.rs1_i : '1;
    end else begin
      special_res = bus.funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // One iteration step.
  // Multiply: acc = {partial, multiplier}; add multiplicand to the upper half
  // when the multiplier LSB is set, then shift right (carry enters at top).
  // Divide: acc = {remainder, dividend/quotient}; shift left one bit, keep
  // the bit shifted out of the remainder (divisor may exceed 2^(XLEN-1)),
  // subtract if it fits and shift the quotient bit in at the bottom.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_top;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] step_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand_b} : '0);
    div_top   = acc[2*XLEN-1:XLEN-1];
    div_ge    = (div_top >= {1'b0, operand_b});
    div_diff  = div_top[XLEN-1:0] - operand_b;
    step_next = '0;
    if (op_q[2]) begin
      step_next = {(div_ge ? div_diff : div_top[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    end else begin
      step_next = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Sign correction on the value produced by the last step.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem, final_res;

  always_comb begin
    prod_fix  = neg_q ? -step_next : step_next;
    quo       = step_next[XLEN-1:0];
    rem       = step_next[2*XLEN-1:XLEN];
    final_res = '0;
    case (op_q)
      3'b000:                 final_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = neg_q ? -quo : quo;
      default:                final_res = neg_r ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      operand_b <= '0;
      acc       <= '0;
      result_q  <= '0;
    end else if (bus.flush_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            op_q      <= bus.funct3_i;
            neg_q     <= a_neg ^ b_neg;
            neg_r     <= a_neg;
            operand_b <= mag_b;
            acc       <= {{XLEN{1'b0}}, mag_a};
            count     <= '0;
            if (is_div0 | is_ovf) begin
              result_q <= special_res;
              state    <= S_DONE;
            end else begin
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          acc   <= step_next;
          count <= count + 1'b1;
          if (count == CW'(XLEN-1)) begin
            result_q <= final_res;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          // start_i is deliberately ignored here, even alongside ack_i.
          if (bus.ack_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall_o  = accept | (state == S_BUSY);
  assign bus.done_o   = (state == S_DONE);
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_m_ext_sequencer.sv
// tb/tb_m_ext_sequencer.sv - self-checking bench for m_ext_sequencer
module tb_m_ext_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  m_ext_sequencer_if #(.XLEN(32)) bus ();

  m_ext_sequencer #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'b000: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'b001: begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
      3'b010: begin sp = longint'(sa) * longint'({32'b0, b}); return sp[63:32]; end
      3'b011: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op, counts stall cycles and latency, checks the result,
  // optionally acks it. Operands are scrambled after acceptance.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit do_ack, input string name);
    logic [31:0] exp;
    int          exp_lat, n_stall, cyc;
    exp     = ref_result(f, a, b);
    exp_lat = is_special(f, a, b) ? 1 : 33;
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.funct3_i = f; bus.rs1_i = a; bus.rs2_i = b;
    bus.flush_i = 1'b0; bus.ack_i = 1'b0;
    #1;
    n_stall = 0;
    cyc = 0;
    while (!bus.done_o && cyc < 200) begin
      if (bus.stall_o) n_stall++;
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.rs1_i = $urandom; bus.rs2_i = $urandom;
      #1;
      cyc++;
    end
    checks++;
    if (cyc !== exp_lat) begin
      failures++;
      $display("FAIL %s latency f=%0d a=%h b=%h: got %0d cycles, expected %0d", name, f, a, b, cyc, exp_lat);
    end
    checks++;
    if (n_stall !== exp_lat) begin
      failures++;
      $display("FAIL %s stall_count: got %0d, expected %0d", name, n_stall, exp_lat);
    end
    checks++;
    if (bus.result_o !== exp || bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL %s result f=%0d a=%h b=%h: got %h stall=%b, expected %h stall=0",
               name, f, a, b, bus.result_o, bus.stall_o, exp);
    end
    if (do_ack) begin
      bus.ack_i = 1'b1;
      @(posedge clk); #1;
      bus.ack_i = 1'b0;
      #1;
      checks++;
      if (bus.done_o !== 1'b0 || bus.stall_o !== 1'b0) begin
        failures++;
        $display("FAIL %s after_ack: done=%b stall=%b, expected 0 0", name, bus.done_o, bus.stall_o);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b0; bus.funct3_i = '0; bus.rs1_i = '0; bus.rs2_i = '0;
    bus.flush_i = 1'b0; bus.ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: stall=%b done=%b result=%h, expected 0 0 0",
               bus.stall_o, bus.done_o, bus.result_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, 1'b1, "mul_dir");
    run_op(3'b001, 32'h80000000, 32'h80000000, 1'b1, "mulh_dir");
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "mulhu_dir");
    run_op(3'b010, 32'hFFFFFFFF, 32'd2, 1'b1, "mulhsu_dir");
    for (int i = 0; i < 16; i++)
      run_op(3'($urandom_range(0, 3)), rand_operand(), rand_operand(), 1'b1, "mul_rand");
  endtask

  task automatic test_div();
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 1'b1, "div_dir");
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, 1'b1, "rem_dir");
    run_op(3'b101, 32'd100, 32'd7, 1'b1, "divu_dir");
    run_op(3'b111, 32'd100, 32'd7, 1'b1, "remu_dir");
    for (int i = 0; i < 16; i++)
      run_op(3'($urandom_range(4, 7)), rand_operand(), rand_operand(), 1'b1, "div_rand");
  endtask

  task automatic test_special();
    run_op(3'b100, $urandom, 32'h0, 1'b1, "div_by_zero");
    run_op(3'b111, 32'h1234, 32'h0, 1'b1, "remu_by_zero");
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 1'b1, "div_overflow");
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b1, "rem_overflow");
  endtask

  task automatic test_flush();
    int seen_done;
    // flush in IDLE suppresses stall in the same cycle and blocks acceptance
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.funct3_i = 3'b000;
    bus.rs1_i = 32'd3; bus.rs2_i = 32'd5;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_stall: got %b, expected 0", bus.stall_o);
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_noaccept: stall=%b done=%b, expected 0 0", bus.stall_o, bus.done_o);
    end
    // flush in BUSY at count 10
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.funct3_i = 3'b101; bus.rs1_i = $urandom; bus.rs2_i = 32'd3;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      failures++;
      $display("FAIL flush_busy_stall: got %b, expected 1", bus.stall_o);
    end
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy_idle: stall=%b done=%b, expected 0 0", bus.stall_o, bus.done_o);
    end
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #2;
      if (bus.done_o) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      failures++;
      $display("FAIL flush_no_done: done seen %0d cycles, expected 0", seen_done);
    end
    run_op(3'b100, 32'hFFFFFF00, 32'd16, 1'b1, "after_flush");
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    int          cyc;
    run_op(3'b000, 32'd1234, 32'd5678, 1'b0, "b2b_first");
    held = ref_result(3'b000, 32'd1234, 32'd5678);
    for (int i = 0; i < 3; i++) begin
      bus.start_i = 1'b1; bus.funct3_i = 3'($urandom_range(0, 7));
      bus.rs1_i = $urandom; bus.rs2_i = $urandom; bus.ack_i = 1'b0;
      @(posedge clk); #2;
      checks++;
      if (bus.done_o !== 1'b1 || bus.result_o !== held || bus.stall_o !== 1'b0) begin
        failures++;
        $display("FAIL b2b_hold%0d: done=%b result=%h stall=%b, expected 1 %h 0",
                 i, bus.done_o, bus.result_o, bus.stall_o, held);
      end
    end
    bus.ack_i = 1'b1; bus.start_i = 1'b1;
    bus.funct3_i = 3'b101; bus.rs1_i = 32'd9; bus.rs2_i = 32'd3;
    @(posedge clk); #1;
    bus.ack_i = 1'b0;
    #1;
    checks++;
    if (bus.done_o !== 1'b0 || bus.stall_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ack_idle: done=%b stall=%b, expected 0 1", bus.done_o, bus.stall_o);
    end
    cyc = 0;
    while (!bus.done_o && cyc < 200) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.rs1_i = $urandom; bus.rs2_i = $urandom;
      #1;
      cyc++;
    end
    checks++;
    if (cyc !== 33 || bus.result_o !== 32'd3) begin
      failures++;
      $display("FAIL b2b_second: latency=%0d result=%h, expected 33 00000003", cyc, bus.result_o);
    end
    bus.ack_i = 1'b1;
    @(posedge clk); #1;
    bus.ack_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.funct3_i = 3'b000; bus.rs1_i = $urandom; bus.rs2_i = $urandom;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_busy: stall=%b done=%b result=%h, expected 0 0 0",
               bus.stall_o, bus.done_o, bus.result_o);
    end
    run_op(3'b011, $urandom, $urandom, 1'b1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
